pe_dot_accum_tree: RTL and testbench
====================================

// Module: pe_dot_accum_tree
// PURPOSE
//   Generic, device-independent signed dot-product reduction tree with a multi-beat accumulator.
//   - Sums DOT_SIZE signed multiplier products per beat through a pipelined pairwise adder tree.
//   - Accumulates consecutive beats framed by i_first/i_last and emits one result per frame.
//   - Sits between the PE multiplier array and the PE output/drain logic, so long dot products
//     split over K beats finish inside the PE.
// PARAMETERS
//   DOT_SIZE   8   products per beat; power of 2, >= 2
//   IN_WIDTH   16  width of each signed two's-complement product
//   ACC_WIDTH  32  accumulator/result width; must be >= IN_WIDTH + $clog2(DOT_SIZE)
//   REG_EVERY  1   tree levels between pipeline registers (1..$clog2(DOT_SIZE))
// PORTS
//   clock       in   1                   rising-edge clock
//   reset       in   1                   synchronous, active-high reset
//   i_valid     in   1                   beat valid; no backpressure, accepted every cycle it is high
//   i_first     in   1                   beat opens a frame (qualified by i_valid)
//   i_last      in   1                   beat closes a frame (qualified by i_valid)
//   i_data      in   IN_WIDTH x DOT_SIZE unpacked array of signed products
//   o_valid     out  1                   one-cycle pulse, o_result holds a completed frame sum
//   o_result    out  ACC_WIDTH           signed frame sum; holds its value between pulses
//   o_overflow  out  1                   frame saturated; valid with o_valid (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: synchronous and active-high; clock and reset are the only clock/reset ports.
//     - Reset values: o_valid=0, o_result=0, o_overflow=0, all pipeline valids=0, state=IDLE,
//       accumulator=0.
//     - Reset mid-frame drops the partial sum and all in-flight beats; no o_valid follows.
//   - Tree:
//     - LEVELS = $clog2(DOT_SIZE). Level n adds pairs of level n-1 outputs, output width +1 bit.
//     - A register follows every REG_EVERY-th level and always the final level.
//     - TREE_LAT = ceil(LEVELS/REG_EVERY).
//     - A valid/first/last sideband shifts alongside the data registers.
//   - Tree output is sign-extended to ACC_WIDTH before accumulation; no rounding.
//   - Accumulator FSM, state in {IDLE, ACCUM}, evaluated on a tree-output valid (tv):
//     - IDLE, tv: acc <= sum. If last: emit, stay IDLE. Otherwise go to ACCUM.
//       A missing first flag is tolerated and the beat opens a frame.
//     - ACCUM, tv & !first: acc <= acc+sum. If last: emit, go to IDLE.
//     - ACCUM, tv & first: the partial frame is discarded silently and acc <= sum (restart);
//       last is then honoured as in IDLE.
//     - No tv: state and acc hold.
//   - Emit: o_result <= final sum and o_valid <= 1 for exactly one cycle.
//   - Latency from an i_valid&i_last beat to o_valid is TREE_LAT+1 cycles (4 for defaults).
//   - Throughput is one beat per clock. Back-to-back single-beat frames (first&last every
//     cycle) give o_valid every cycle.
//   - Without saturation, arithmetic wraps modulo 2^ACC_WIDTH.
// CONFIGURATION
//   - Macro PE_DOT_ACC_SAT_EN defined:
//     - Each accumulate is computed at ACC_WIDTH+1 bits. Results out of range clamp to
//       2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
//     - A sticky per-frame flag records any clamp and is presented on o_overflow with o_valid.
//     - The flag is cleared when a frame opens; later beats continue from the clamped value.
//   - Macro undefined:
//     - Wrap-around arithmetic; o_overflow is tied to 0 and no comparison logic is built.
// STRUCTURE
//   - pe_types package gains:
//     - enum pe_dot_acc_state_e {IDLE, ACCUM}
//     - function pe_dot_tree_lat(dot_size, reg_every) returning TREE_LAT, shared with the
//       PE control and the bench.
//   - Sub-module pe_dot_tree_level #(NUM, WIDTH, REGISTERED):
//     - One level of NUM/2 signed pairwise adders plus optional output register and sideband.
//     - Instantiated LEVELS times in a generate loop.
//   - The top holds the accumulator FSM and saturation logic.
// TESTING
//   1. Defaults, one beat i_data={1,2,3,4,5,6,7,8}, first=last=1
//      -> o_valid exactly 4 cycles later, o_result=36.
//   2. Frame of 3 beats: all +100, all -50, all +1 (8 lanes), first on beat 0, last on beat 2
//      -> one o_valid, o_result=408.
//   3. first&last on every cycle for 10 cycles with lane values k
//      -> 10 consecutive o_valid pulses, o_result=8k each, in order.
//   4. Open a frame of 2 beats of all 10, then re-assert first with a single all-1 last beat
//      -> only one o_valid, o_result=8 (partial discarded).
//   5. Assert reset for 1 cycle two beats into a 4-beat frame, then send a single first&last
//      all-2 beat -> no result from the aborted frame, then o_result=16.
//   6. ACC_WIDTH=20, IN_WIDTH=16, 4 beats of all 32767
//      -> with PE_DOT_ACC_SAT_EN: o_result=524287, o_overflow=1.
//      -> without the macro: o_result=(4*8*32767) mod 2^20 interpreted signed = -32, o_overflow=0.

Source files
------------

// File: rtl/pe_types_pkg.sv
// ============================================================================
// Package  : pe_types
// Desc     : Shared PE types: dot-product accumulator states and the helper
//            that gives the reduction-tree pipeline depth.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pe_types;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_dot_acc_state_e;

  // Number of register stages in the pairwise adder tree.
  function automatic int pe_dot_tree_lat(input int dot_size, input int reg_every);
    int levels;
    levels = $clog2(dot_size);
    return (levels + reg_every - 1) / reg_every;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_dot_tree_level.sv
// ============================================================================
// Module   : pe_dot_tree_level
// Desc     : One level of signed pairwise adders with an optional output
//            register; the valid/first/last sideband follows the data.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_dot_tree_level #(
  parameter int NUM        = 2,
  parameter int WIDTH      = 16,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic                           i_first,
  input  logic                           i_last,
  input  logic [NUM*WIDTH-1:0]           i_data,
  output logic                           o_valid,
  output logic                           o_first,
  output logic                           o_last,
  output logic [(NUM/2)*(WIDTH+1)-1:0]   o_data
);

  localparam int c_PAIRS = NUM / 2;

  logic [c_PAIRS*(WIDTH+1)-1:0] w_sum;

  for (genvar p = 0; p < c_PAIRS; p++) begin : g_pair
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    assign w_a = i_data[(2*p)*WIDTH +: WIDTH];
    assign w_b = i_data[(2*p+1)*WIDTH +: WIDTH];
    // One guard bit per level keeps the signed pair sum exact.
    assign w_sum[p*(WIDTH+1) +: WIDTH+1] = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
  end

  if (REGISTERED) begin : g_reg
    logic                         r_valid;
    logic                         r_first;
    logic                         r_last;
    logic [c_PAIRS*(WIDTH+1)-1:0] r_data;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_valid <= i_valid;
        r_first <= i_first;
        r_last  <= i_last;
      end
      r_data <= w_sum;
    end

    assign o_valid = r_valid;
    assign o_first = r_first;
    assign o_last  = r_last;
    assign o_data  = r_data;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset};
    assign o_valid  = i_valid;
    assign o_first  = i_first;
    assign o_last   = i_last;
    assign o_data   = w_sum;
  end

endmodule

`default_nettype wire

// File: rtl/pe_dot_accum_tree.sv
// ============================================================================
// Module   : pe_dot_accum_tree
// Desc     : Signed dot-product adder tree feeding a framed multi-beat
//            accumulator. Optional saturation: define PE_DOT_ACC_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_dot_accum_tree
  import pe_types::*;
#(
  parameter int DOT_SIZE  = 8,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int REG_EVERY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic                        i_first,
  input  logic                        i_last,
  input  logic signed [IN_WIDTH-1:0]  i_data [DOT_SIZE],
  output logic                        o_valid,
  output logic signed [ACC_WIDTH-1:0] o_result,
  output logic                        o_overflow
);

  localparam int c_LEVELS = $clog2(DOT_SIZE);
  localparam int c_SUM_W  = IN_WIDTH + c_LEVELS;

  logic [DOT_SIZE*IN_WIDTH-1:0] w_flat;

  for (genvar i = 0; i < DOT_SIZE; i++) begin : g_flat
    assign w_flat[i*IN_WIDTH +: IN_WIDTH] = i_data[i];
  end

  for (genvar l = 0; l < c_LEVELS; l++) begin : g_lvl
    localparam int c_NUM = DOT_SIZE >> l;
    localparam int c_W   = IN_WIDTH + l;
    // Register after every REG_EVERY-th level, and always after the last one.
    localparam bit c_REG = (((l + 1) % REG_EVERY) == 0) || (l == c_LEVELS - 1);

    logic [c_NUM*c_W-1:0]           w_in;
    logic                           w_iv;
    logic                           w_if;
    logic                           w_il;
    logic [(c_NUM/2)*(c_W+1)-1:0]   w_out;
    logic                           w_ov;
    logic                           w_of;
    logic                           w_ol;

    if (l == 0) begin : g_src
      assign w_in = w_flat;
      assign w_iv = i_valid;
      assign w_if = i_first;
      assign w_il = i_last;
    end else begin : g_src
      assign w_in = g_lvl[l-1].w_out;
      assign w_iv = g_lvl[l-1].w_ov;
      assign w_if = g_lvl[l-1].w_of;
      assign w_il = g_lvl[l-1].w_ol;
    end

    pe_dot_tree_level #(
      .NUM        (c_NUM),
      .WIDTH      (c_W),
      .REGISTERED (c_REG)
    ) u_level (
      .clock   (clock),
      .reset   (reset),
      .i_valid (w_iv),
      .i_first (w_if),
      .i_last  (w_il),
      .i_data  (w_in),
      .o_valid (w_ov),
      .o_first (w_of),
      .o_last  (w_ol),
      .o_data  (w_out)
    );
  end

  logic                        w_tv;
  logic                        w_tfirst;
  logic                        w_tlast;
  logic signed [c_SUM_W-1:0]   w_tsum;
  logic signed [ACC_WIDTH-1:0] w_sum_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_open;

  assign w_tv      = g_lvl[c_LEVELS-1].w_ov;
  assign w_tfirst  = g_lvl[c_LEVELS-1].w_of;
  assign w_tlast   = g_lvl[c_LEVELS-1].w_ol;
  assign w_tsum    = g_lvl[c_LEVELS-1].w_out;
  assign w_sum_ext = ACC_WIDTH'(w_tsum);

  pe_dot_acc_state_e r_state;
  pe_dot_acc_state_e w_state_next;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_result;
  logic                        r_valid;

  // A beat opens a frame when idle or when first restarts a partial frame.
  assign w_open = (r_state == IDLE) || w_tfirst;
  assign w_base = w_open ? '0 : r_acc;

`ifdef PE_DOT_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] c_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] w_wide;
  logic               w_clamp;
  logic               w_ovf_next;
  logic               r_ovf;
  logic               r_ovf_out;

  assign w_wide     = {w_base[ACC_WIDTH-1], w_base} + {w_sum_ext[ACC_WIDTH-1], w_sum_ext};
  assign w_clamp    = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
  assign w_acc_next = !w_clamp ? w_wide[ACC_WIDTH-1:0] : (w_wide[ACC_WIDTH] ? c_MIN : c_MAX);
  assign w_ovf_next = (w_open ? 1'b0 : r_ovf) | w_clamp;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
    end else begin
      if (w_tv) begin
        r_ovf <= w_ovf_next;
      end
      if (w_tv && w_tlast) begin
        r_ovf_out <= w_ovf_next;
      end
    end
  end

  assign o_overflow = r_ovf_out;
`else
  assign w_acc_next = w_base + w_sum_ext;
  assign o_overflow = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    if (w_tv) begin
      w_state_next = w_tlast ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_tv && w_tlast;
      if (w_tv) begin
        r_acc <= w_acc_next;
      end
      if (w_tv && w_tlast) begin
        r_result <= w_acc_next;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_pe_dot_accum_tree.sv
// ============================================================================
// Module   : tb_pe_dot_accum_tree
// Desc     : Self-checking bench for pe_dot_accum_tree (default build and a
//            20-bit accumulator instance) against a frame-level sum model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_dot_accum_tree;
  import pe_types::*;

  localparam int DOT = 8;
  localparam int INW = 16;
  localparam int LAT = pe_dot_tree_lat(DOT, 1) + 1;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic i_valid = 1'b0;
  logic i_first = 1'b0;
  logic i_last  = 1'b0;
  logic signed [INW-1:0] i_data [DOT];

  logic               o_valid;
  logic signed [31:0] o_result;
  logic               o_overflow;
  logic               o_valid20;
  logic signed [19:0] o_result20;
  logic               o_overflow20;

  always #5 clock = ~clock;

  pe_dot_accum_tree #(.DOT_SIZE(DOT), .IN_WIDTH(INW), .ACC_WIDTH(32), .REG_EVERY(1)) u_dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_data(i_data), .o_valid(o_valid), .o_result(o_result), .o_overflow(o_overflow)
  );

  pe_dot_accum_tree #(.DOT_SIZE(DOT), .IN_WIDTH(INW), .ACC_WIDTH(20), .REG_EVERY(1)) u_dut20 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_data(i_data), .o_valid(o_valid20), .o_result(o_result20), .o_overflow(o_overflow20)
  );

  typedef struct {
    longint val;
    bit     ovf;
    int     cyc;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   lanes [DOT];
  res_t exp32_q[$];
  res_t exp20_q[$];
  res_t cap32_q[$];
  res_t cap20_q[$];
  res_t cap_r;

  // Reference model: frame-level running sums for both accumulator widths.
  bit     m_open;
  longint m_acc32, m_acc20;
  bit     m_ovf32, m_ovf20;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (o_valid) begin
      cap_r.val = o_result;
      cap_r.ovf = o_overflow;
      cap_r.cyc = cyc;
      cap32_q.push_back(cap_r);
    end
    if (o_valid20) begin
      cap_r.val = o_result20;
      cap_r.ovf = o_overflow20;
      cap_r.cyc = cyc;
      cap20_q.push_back(cap_r);
    end
  end

  function automatic longint acc_step(input longint acc, input longint s, input int w, inout bit ovf);
    longint r;
    longint m;
    longint hi;
    longint lo;
    r  = acc + s;
    m  = longint'(1) << w;
    hi = (m / 2) - 1;
    lo = -(m / 2);
`ifdef PE_DOT_ACC_SAT_EN
    if (r > hi) begin
      r   = hi;
      ovf = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      ovf = 1'b1;
    end
`else
    r = ((r % m) + m) % m;
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_queues();
    exp32_q.delete();
    exp20_q.delete();
    cap32_q.delete();
    cap20_q.delete();
  endtask

  task automatic model_reset();
    m_open = 1'b0;
    exp32_q.delete();
    exp20_q.delete();
  endtask

  // Drives one beat from lanes[] and advances the reference model.
  task automatic send(input bit f, input bit l);
    longint s;
    res_t   e;
    s = 0;
    for (int i = 0; i < DOT; i++) begin
      i_data[i] = INW'(lanes[i]);
      s += lanes[i];
    end
    i_valid = 1'b1;
    i_first = f;
    i_last  = l;
    if (!m_open || f) begin
      m_acc32 = 0;
      m_acc20 = 0;
      m_ovf32 = 1'b0;
      m_ovf20 = 1'b0;
    end
    m_acc32 = acc_step(m_acc32, s, 32, m_ovf32);
    m_acc20 = acc_step(m_acc20, s, 20, m_ovf20);
    if (l) begin
      e.cyc = cyc + LAT;
      e.val = m_acc32;
      e.ovf = m_ovf32;
      exp32_q.push_back(e);
      e.val = m_acc20;
      e.ovf = m_ovf20;
      exp20_q.push_back(e);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
    tick();
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < DOT; i++) lanes[i] = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DOT; i++) i_data[i] = '0;
    repeat (3) tick();
    checks++;
    if ({o_valid, o_result, o_overflow} !== 34'd0) begin
      errors++;
      $display("FAIL reset32 got v=%0b r=%0d o=%0b want 0/0/0", o_valid, o_result, o_overflow);
    end
    checks++;
    if ({o_valid20, o_result20, o_overflow20} !== 22'd0) begin
      errors++;
      $display("FAIL reset20 got v=%0b r=%0d o=%0b want 0/0/0", o_valid20, o_result20, o_overflow20);
    end
    reset = 1'b0;
    model_reset();
    tick();
    clear_queues();
  endtask

  task automatic test_single();
    for (int i = 0; i < DOT; i++) lanes[i] = i + 1;
    send(1'b1, 1'b1);
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", cap32_q.size());
    end
    if (cap32_q.size() > 0 && exp32_q.size() > 0) begin
      checks++;
      if (cap32_q[0].val !== 64'sd36 || cap32_q[0].cyc !== exp32_q[0].cyc || cap32_q[0].ovf !== 1'b0) begin
        errors++;
        $display("FAIL single_result got %0d@%0d ovf=%0b want 36@%0d ovf=0",
                 cap32_q[0].val, cap32_q[0].cyc, cap32_q[0].ovf, exp32_q[0].cyc);
      end
    end
    clear_queues();
  endtask

  task automatic test_frame();
    fill(100);
    send(1'b1, 1'b0);
    fill(-50);
    send(1'b0, 1'b0);
    fill(1);
    send(1'b0, 1'b1);
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != 1) begin
      errors++;
      $display("FAIL frame_count got %0d want 1", cap32_q.size());
    end
    if (cap32_q.size() > 0 && exp32_q.size() > 0) begin
      checks++;
      if (cap32_q[0].val !== 64'sd408 || cap32_q[0].cyc !== exp32_q[0].cyc) begin
        errors++;
        $display("FAIL frame_result got %0d@%0d want 408@%0d", cap32_q[0].val, cap32_q[0].cyc, exp32_q[0].cyc);
      end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 10; k++) begin
      fill(k);
      send(1'b1, 1'b1);
    end
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != 10) begin
      errors++;
      $display("FAIL b2b_count got %0d want 10", cap32_q.size());
    end
    for (int k = 0; k < 10 && k < cap32_q.size() && k < exp32_q.size(); k++) begin
      checks++;
      if (cap32_q[k].val !== longint'(8 * (k + 1)) || cap32_q[k].cyc !== exp32_q[0].cyc + k) begin
        errors++;
        $display("FAIL b2b_result[%0d] got %0d@%0d want %0d@%0d", k, cap32_q[k].val, cap32_q[k].cyc,
                 8 * (k + 1), exp32_q[0].cyc + k);
      end
    end
    clear_queues();
  endtask

  task automatic test_restart();
    fill(10);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    fill(1);
    send(1'b1, 1'b1);
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != 1) begin
      errors++;
      $display("FAIL restart_count got %0d want 1", cap32_q.size());
    end
    if (cap32_q.size() > 0) begin
      checks++;
      if (cap32_q[0].val !== 64'sd8) begin
        errors++;
        $display("FAIL restart_result got %0d want 8", cap32_q[0].val);
      end
    end
    clear_queues();
  endtask

  task automatic test_mid_reset();
    fill(5);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    checks++;
    if (o_result !== 32'sd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got v=%0b r=%0d want v=0 r=0", o_valid, o_result);
    end
    fill(2);
    send(1'b1, 1'b1);
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != 1 || cap20_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count got %0d/%0d want 1/1", cap32_q.size(), cap20_q.size());
    end
    if (cap32_q.size() > 0) begin
      checks++;
      if (cap32_q[0].val !== 64'sd16) begin
        errors++;
        $display("FAIL midreset_result got %0d want 16", cap32_q[0].val);
      end
    end
    clear_queues();
  endtask

  task automatic test_saturation();
    longint want20;
    bit     want_ovf;
`ifdef PE_DOT_ACC_SAT_EN
    want20   = 524287;
    want_ovf = 1'b1;
`else
    want20   = -32;
    want_ovf = 1'b0;
`endif
    fill(32767);
    for (int b = 0; b < 4; b++) send(b == 0, b == 3);
    repeat (LAT + 4) tick();
    checks++;
    if (cap20_q.size() != 1 || cap32_q.size() != 1) begin
      errors++;
      $display("FAIL sat_count got %0d/%0d want 1/1", cap20_q.size(), cap32_q.size());
    end
    if (cap20_q.size() > 0) begin
      checks++;
      if (cap20_q[0].val !== want20 || cap20_q[0].ovf !== want_ovf) begin
        errors++;
        $display("FAIL sat_result20 got %0d ovf=%0b want %0d ovf=%0b", cap20_q[0].val, cap20_q[0].ovf,
                 want20, want_ovf);
      end
    end
    if (cap32_q.size() > 0) begin
      checks++;
      if (cap32_q[0].val !== 64'sd1048544 || cap32_q[0].ovf !== 1'b0) begin
        errors++;
        $display("FAIL sat_result32 got %0d ovf=%0b want 1048544 ovf=0", cap32_q[0].val, cap32_q[0].ovf);
      end
    end
    clear_queues();
  endtask

  task automatic test_random();
    for (int fr = 0; fr < 60; fr++) begin
      int len;
      bit big;
      len = $urandom_range(1, 4);
      big = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < len; b++) begin
        bit f;
        f = (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
        for (int i = 0; i < DOT; i++) begin
          if (big) lanes[i] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
          else     lanes[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        send(f, b == len - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    repeat (LAT + 4) tick();
    checks++;
    if (cap32_q.size() != exp32_q.size() || cap20_q.size() != exp20_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d/%0d want %0d/%0d", cap32_q.size(), cap20_q.size(),
               exp32_q.size(), exp20_q.size());
    end
    for (int k = 0; k < cap32_q.size() && k < exp32_q.size(); k++) begin
      checks++;
      if (cap32_q[k].val !== exp32_q[k].val || cap32_q[k].ovf !== exp32_q[k].ovf ||
          cap32_q[k].cyc !== exp32_q[k].cyc) begin
        errors++;
        $display("FAIL rand32[%0d] got %0d ovf=%0b @%0d want %0d ovf=%0b @%0d", k, cap32_q[k].val,
                 cap32_q[k].ovf, cap32_q[k].cyc, exp32_q[k].val, exp32_q[k].ovf, exp32_q[k].cyc);
      end
    end
    for (int k = 0; k < cap20_q.size() && k < exp20_q.size(); k++) begin
      checks++;
      if (cap20_q[k].val !== exp20_q[k].val || cap20_q[k].ovf !== exp20_q[k].ovf ||
          cap20_q[k].cyc !== exp20_q[k].cyc) begin
        errors++;
        $display("FAIL rand20[%0d] got %0d ovf=%0b @%0d want %0d ovf=%0b @%0d", k, cap20_q[k].val,
                 cap20_q[k].ovf, cap20_q[k].cyc, exp20_q[k].val, exp20_q[k].ovf, exp20_q[k].cyc);
      end
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_back_to_back();
    test_restart();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
